// File: rtl/pipelined_adder_n_pkg.sv
// Shared definitions for the pipelined adder: opcode encodings and the
// full-adder cell that the ripple slices are built from.
package pipelined_adder_n_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Full-adder sum bit.
  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  // Full-adder carry bit.
  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (c & (x ^ y));
  endfunction

  // Carry into the lowest slice: subtraction supplies the +1 of two's complement.
  function automatic logic stage0_cin(input logic op, input logic carryin);
    return (op == OP_SUB) ? 1'b1 : carryin;
  endfunction

endpackage

// File: rtl/pipelined_adder_n_slice.sv
// Purely combinational SLICE_W-bit ripple-carry slice built from full-adder cells.
module pipelined_adder_n_slice
  import pipelined_adder_n_pkg::*;
#(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_sum,
  output logic               o_cout
);

  logic [SLICE_W:0] w_c;

  // Ripple the carry bit by bit through the full-adder cells.
  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < SLICE_W; i++) begin
      o_sum[i]  = fa_sum(i_a[i], i_b[i], w_c[i]);
      w_c[i+1]  = fa_carry(i_a[i], i_b[i], w_c[i]);
    end
  end

  assign o_cout = w_c[SLICE_W];

endmodule

// File: rtl/pipelined_adder_n.sv
// Pipelined two's-complement adder/subtractor. Each stage resolves one
// SLICE_W-bit slice; unresolved operand slices ride along skewed, resolved
// sum slices accumulate into the deskewed result. A single global advance
// signal stalls every stage together, so bubbles are kept in place.
module pipelined_adder_n
  import pipelined_adder_n_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int STAGES = WIDTH / SLICE_W;

  if (WIDTH % SLICE_W != 0) begin : g_width_check
    $error("pipelined_adder_n: WIDTH must be an integer multiple of SLICE_W");
  end

  // Insert resolved slice idx into a partially built sum word.
  function automatic logic [WIDTH-1:0] put_slice(input logic [WIDTH-1:0] base,
                                                 input logic [SLICE_W-1:0] s,
                                                 input int idx);
    logic [WIDTH-1:0] r;
    r = base;
    r[idx*SLICE_W +: SLICE_W] = s;
    return r;
  endfunction

  logic               w_adv;
  logic [STAGES-1:0]  r_vld;
  logic [STAGES-1:0]  w_vld_in;

  // Per-stage inputs (operands, sub flag, carry, partial sum) and slice results.
  logic [WIDTH-1:0]   w_a_in     [STAGES];
  logic [WIDTH-1:0]   w_b_in     [STAGES];
  logic [WIDTH-1:0]   w_s_in     [STAGES];
  logic               w_sub_in   [STAGES];
  logic               w_cin      [STAGES];
  logic [SLICE_W-1:0] w_bs       [STAGES];
  logic [SLICE_W-1:0] w_slice_sum[STAGES];
  logic               w_slice_co [STAGES];
  logic [WIDTH-1:0]   w_s_next   [STAGES];

  // Registered stage outputs feeding the next stage.
  logic [WIDTH-1:0]   w_a_q      [STAGES];
  logic [WIDTH-1:0]   w_b_q      [STAGES];
  logic [WIDTH-1:0]   w_s_q      [STAGES];
  logic               w_sub_q    [STAGES];
  logic               w_c_q      [STAGES];

  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;
  logic               r_zero;

  assign w_adv     = !r_vld[STAGES-1] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld[STAGES-1];
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_ovf;
  assign zero      = r_zero;

  if (STAGES == 1) begin : g_vld_single
    assign w_vld_in = in_valid;
  end else begin : g_vld_multi
    assign w_vld_in = {r_vld[STAGES-2:0], in_valid};
  end

  // Stage valid bits shift together on every advance; bubbles are preserved.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
    end else if (w_adv) begin
      r_vld <= w_vld_in;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SLICE_W;

    if (k == 0) begin : g_first
      assign w_a_in[k]   = a;
      assign w_b_in[k]   = b;
      assign w_sub_in[k] = sub;
      assign w_cin[k]    = stage0_cin(sub, carryin);
      assign w_s_in[k]   = '0;
    end else begin : g_next
      assign w_a_in[k]   = w_a_q[k-1];
      assign w_b_in[k]   = w_b_q[k-1];
      assign w_sub_in[k] = w_sub_q[k-1];
      assign w_cin[k]    = w_c_q[k-1];
      assign w_s_in[k]   = w_s_q[k-1];
    end

    assign w_bs[k] = (w_sub_in[k] == OP_ADD) ? w_b_in[k][LO +: SLICE_W]
                                             : ~w_b_in[k][LO +: SLICE_W];

    pipelined_adder_n_slice #(.SLICE_W(SLICE_W)) u_slice (
      .i_a   (w_a_in[k][LO +: SLICE_W]),
      .i_b   (w_bs[k]),
      .i_cin (w_cin[k]),
      .o_sum (w_slice_sum[k]),
      .o_cout(w_slice_co[k])
    );

    assign w_s_next[k] = put_slice(w_s_in[k], w_slice_sum[k], k);

    if (k < STAGES - 1) begin : g_mid
      // ---- stage k -> stage k+1 boundary ----
      logic [WIDTH-1:0] r_a_p;
      logic [WIDTH-1:0] r_b_p;
      logic [WIDTH-1:0] r_s_p;
      logic             r_sub_p;
      logic             r_c_p;

      // Carry the beat forward: skewed operands, partial sum, carry and op.
      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_a_p   <= w_a_in[k];
          r_b_p   <= w_b_in[k];
          r_s_p   <= w_s_next[k];
          r_sub_p <= w_sub_in[k];
          r_c_p   <= w_slice_co[k];
        end
      end

      assign w_a_q[k]   = r_a_p;
      assign w_b_q[k]   = r_b_p;
      assign w_s_q[k]   = r_s_p;
      assign w_sub_q[k] = r_sub_p;
      assign w_c_q[k]   = r_c_p;
    end else begin : g_last
      // ---- last stage -> output register boundary ----
      assign w_a_q[k]   = '0;
      assign w_b_q[k]   = '0;
      assign w_s_q[k]   = '0;
      assign w_sub_q[k] = 1'b0;
      assign w_c_q[k]   = 1'b0;

      // Capture the deskewed result and flags from the MSB slice inputs.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sum  <= '0;
          r_cout <= 1'b0;
          r_ovf  <= 1'b0;
          r_zero <= 1'b0;
        end else if (w_adv && w_vld_in[k]) begin
          r_sum  <= w_s_next[k];
          r_cout <= w_slice_co[k];
          r_ovf  <= (w_a_in[k][WIDTH-1] == w_bs[k][SLICE_W-1]) &&
                    (w_s_next[k][WIDTH-1] != w_a_in[k][WIDTH-1]);
          r_zero <= ~|w_s_next[k];
        end
      end
    end
  end

endmodule
